// File: rtl/clk_rst_seq.sv
// Reset sequencer and clock-enable tick generator between the clock generator and the plotter core.
// Releases core_reset only after lock has been stable; all channels are enables on the single clk.
module clk_rst_seq #(
    parameter int NUM_CH      = 4,
    parameter int DIV_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 1024
) (
    input  logic                        clk,
    input  logic                        n_reset,
    input  logic                        lock,
    input  logic [NUM_CH*DIV_WIDTH-1:0] div_val,
    input  logic [NUM_CH-1:0]           div_load,
    input  logic [NUM_CH-1:0]           ch_en,
    output logic                        core_reset,
    output logic                        ready,
    output logic [NUM_CH-1:0]           tick,
    output logic                        lock_lost
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        SETTLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] rst_pipe;
    logic                   rst_rel;
    logic [SYNC_STAGES-1:0] lock_pipe;
    logic                   lock_s;

    state_t             state;
    state_t             state_nx;
    logic [SET_W-1:0]   settle_cnt;
    logic [SET_W-1:0]   settle_nx;
    logic               lost_nx;
    logic               run;

    logic [NUM_CH-1:0][DIV_WIDTH-1:0] shadow;
    logic [NUM_CH-1:0][DIV_WIDTH-1:0] active;
    logic [NUM_CH-1:0][DIV_WIDTH-1:0] count;
    logic [NUM_CH-1:0]                wrap;

    // Reset assertion is immediate; release is retimed onto clk.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rst_pipe <= '0;
        end else begin
            rst_pipe <= {rst_pipe[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_rel = rst_pipe[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            lock_pipe <= '0;
        end else if (!rst_rel) begin
            lock_pipe <= '0;
        end else begin
            lock_pipe <= {lock_pipe[SYNC_STAGES-2:0], lock};
        end
    end

    assign lock_s = lock_pipe[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= HOLD;
            settle_cnt <= '0;
            lock_lost  <= 1'b0;
        end else if (!rst_rel) begin
            state      <= HOLD;
            settle_cnt <= '0;
            lock_lost  <= 1'b0;
        end else begin
            state      <= state_nx;
            settle_cnt <= settle_nx;
            lock_lost  <= lost_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        settle_nx = '0;
        lost_nx   = lock_lost;
        case (state)
            HOLD:      state_nx = WAIT_LOCK;
            WAIT_LOCK: if (lock_s) state_nx = SETTLE;
            SETTLE: begin
                // Any dropout restarts the settle window from zero.
                if (!lock_s) begin
                    state_nx = WAIT_LOCK;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nx = RUN;
                end else begin
                    settle_nx = settle_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nx = HOLD;
                    lost_nx  = 1'b1;
                end
            end
            default: state_nx = HOLD;
        endcase
    end

    always_comb begin
        run        = (state == RUN);
        ready      = run;
        core_reset = !run;
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wrap[i] = run && ch_en[i] && (active[i] != '0)
                      && (count[i] == active[i] - DIV_WIDTH'(1));
        end
    end

    assign tick = wrap;

    // A divisor written mid-period only takes effect at the next wrap, so no period is cut short.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            shadow <= '0;
            active <= '0;
            count  <= '0;
        end else if (!rst_rel) begin
            shadow <= '0;
            active <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (div_load[i]) begin
                    shadow[i] <= div_val[i*DIV_WIDTH +: DIV_WIDTH];
                end
                if ((active[i] == '0) || !ch_en[i] || wrap[i]) begin
                    active[i] <= shadow[i];
                end
                if (run && ch_en[i] && (active[i] != '0) && !wrap[i]) begin
                    count[i] <= count[i] + DIV_WIDTH'(1);
                end else begin
                    count[i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed bench for clk_rst_seq: reset/lock sequencing, settle timing, tick schedules.
// Expected tick cycles are queued on RUN entry and matched every cycle.
module tb_clk_rst_seq;

    logic        clk;
    logic        n_reset;
    logic        lock;
    logic [63:0] div_val;
    logic [3:0]  div_load;
    logic [3:0]  ch_en;
    logic        core_reset;
    logic        ready;
    logic [3:0]  tick;
    logic        lock_lost;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int run_start = 0;
    bit arm_run = 0;
    int exp_q[4][$];

    clk_rst_seq #(
        .NUM_CH(4),
        .DIV_WIDTH(16),
        .SYNC_STAGES(2),
        .SETTLE_CYC(16)
    ) dut (
        .clk(clk),
        .n_reset(n_reset),
        .lock(lock),
        .div_val(div_val),
        .div_load(div_load),
        .ch_en(ch_en),
        .core_reset(core_reset),
        .ready(ready),
        .tick(tick),
        .lock_lost(lock_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", name, cyc, obs, expv);
        end
    endtask

    // Expected tick cycles given as offsets from the first RUN cycle.
    task automatic push_seq(input int ch, input int first, input int step, input int last);
        for (int r = first; r <= last; r += step) exp_q[ch].push_back(run_start + r);
    endtask

    task automatic push_schedule();
        // ch0: div 5, reload 7 at r=31 (mid-period), reload 3 on the r=55 wrap (takes effect a wrap later)
        push_seq(0, 4, 5, 34);
        push_seq(0, 41, 7, 62);
        push_seq(0, 65, 3, 91);
        // ch1: div 1 ticks every RUN cycle until lock loss lands at r=92
        push_seq(1, 0, 1, 91);
        // ch3: div 4, enable sampled low at the end of r=73 clears counter
        push_seq(3, 3, 4, 71);
        push_seq(3, 77, 4, 91);
    endtask

    task automatic cycle();
        @(negedge clk);
        if (arm_run && ready === 1'b1) begin
            arm_run   = 0;
            run_start = cyc;
            push_schedule();
        end
        for (int i = 0; i < 4; i++) begin
            bit e;
            e = (exp_q[i].size() > 0) && (exp_q[i][0] == cyc);
            if (e) void'(exp_q[i].pop_front());
            check($sformatf("tick[%0d]", i), 32'(tick[i]), 32'(e));
        end
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic run_to(input int r);
        while (cyc < run_start + r) cycle();
    endtask

    task automatic wait_ready(input int max_cyc);
        bit seen = 0;
        for (int k = 0; k < max_cyc && !seen; k++) begin
            cycle();
            if (ready === 1'b1) seen = 1;
            else check("core_reset_before_run", 32'(core_reset), 32'd1);
        end
        if (arm_run) begin
            arm_run   = 0;
            run_start = cyc;
        end
        check("ready_reached", 32'(ready), 32'd1);
        check("core_reset_in_run", 32'(core_reset), 32'd0);
    endtask

    initial begin
        n_reset  = 1'b0;
        lock     = 1'b1;
        div_val  = '0;
        div_load = '0;
        ch_en    = '0;

        // Reset held with lock already high
        cycles(5);
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_lock_lost", 32'(lock_lost), 32'd0);

        n_reset = 1'b1;
        cycles(4);
        div_val  = {16'd4, 16'd0, 16'd1, 16'd5};
        div_load = 4'hF;
        ch_en    = 4'hF;
        cycle();
        div_load = 4'h0;

        arm_run = 1;
        wait_ready(60);
        check("run_lock_lost", 32'(lock_lost), 32'd0);

        // Divisor reloads while ticking
        run_to(31);
        div_val  = {16'd4, 16'd0, 16'd1, 16'd7};
        div_load = 4'b0001;
        run_to(32);
        div_load = 4'b0000;
        run_to(55);
        div_val  = {16'd4, 16'd0, 16'd1, 16'd3};
        div_load = 4'b0001;
        run_to(56);
        div_load = 4'b0000;

        // One-cycle disable of ch3
        run_to(73);
        ch_en = 4'b0111;
        run_to(74);
        ch_en = 4'hF;

        // Lock loss: two sync flops, then the FSM edge
        run_to(89);
        lock = 1'b0;
        run_to(91);
        check("lost_still_ready", 32'(ready), 32'd1);
        check("lost_still_run_rst", 32'(core_reset), 32'd0);
        check("lost_flag_before", 32'(lock_lost), 32'd0);
        run_to(92);
        check("lost_core_reset", 32'(core_reset), 32'd1);
        check("lost_ready", 32'(ready), 32'd0);
        check("lost_tick", 32'(tick), 32'd0);
        check("lost_flag", 32'(lock_lost), 32'd1);
        ch_en = 4'h0;

        // Short lock pulse aborts settle
        run_to(100);
        lock = 1'b1;
        run_to(110);
        lock = 1'b0;
        while (cyc < run_start + 140) begin
            cycle();
            check("pulse_no_ready", 32'(ready), 32'd0);
            check("pulse_core_reset", 32'(core_reset), 32'd1);
        end
        lock = 1'b1;
        run_to(158);
        check("relock_not_yet", 32'(ready), 32'd0);
        run_to(159);
        check("relock_ready", 32'(ready), 32'd1);
        check("relock_core_reset", 32'(core_reset), 32'd0);
        check("relock_lost_held", 32'(lock_lost), 32'd1);

        // n_reset pulse clears the sticky flag and the divisors
        run_to(160);
        n_reset = 1'b0;
        cycle();
        check("nrst_core_reset", 32'(core_reset), 32'd1);
        check("nrst_ready", 32'(ready), 32'd0);
        check("nrst_lock_lost", 32'(lock_lost), 32'd0);
        cycles(2);
        n_reset = 1'b1;
        ch_en   = 4'hF;
        wait_ready(60);
        check("after_nrst_lost", 32'(lock_lost), 32'd0);
        cycles(20);

        for (int i = 0; i < 4; i++) check($sformatf("sched_left[%0d]", i), 32'(exp_q[i].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
